// File: rtl/mux21_lane_merge_pkg.sv
// Shared width, depth and lane-order definitions for the 1:2 byte demux and
// its 2:1 lane merger, so both ends stripe and restore bytes identically.
package mux21_lane_merge_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  // Lane index constants; the demux stripes LANE0 first, so the merger drains it first.
  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

endpackage

// File: rtl/mux21_lane_merge_lane_fifo.sv
// Per-lane synchronous FIFO. A push into a full FIFO is accepted only when the
// same cycle pops; otherwise the byte is dropped and drop pulses for one cycle.
module lane_fifo #(
  parameter int DATA_W = mux21_lane_merge_pkg::DATA_W,
  parameter int DEPTH  = mux21_lane_merge_pkg::DEPTH,
  parameter int ADDR_W = mux21_lane_merge_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/mux21_lane_merge.sv
// Merges two byte lanes into one stream by draining the lane FIFOs in strict
// lane 0 / lane 1 alternation; stalls on the expected lane rather than skipping.
module mux21_lane_merge #(
  parameter int DATA_W = mux21_lane_merge_pkg::DATA_W,
  parameter int DEPTH  = mux21_lane_merge_pkg::DEPTH,
  parameter int ADDR_W = mux21_lane_merge_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [1:0]        valid_in,
  output logic [DATA_W-1:0] out,
  output logic              valid_out,
  output logic [1:0]        overflow,
  output logic [1:0]        fifo_empty
);

  import mux21_lane_merge_pkg::*;

  logic [DATA_W-1:0] lane_din  [2];
  logic [DATA_W-1:0] lane_dout [2];
  logic [1:0]        lane_pop;
  logic [1:0]        lane_empty;
  logic [1:0]        lane_full;
  logic [1:0]        lane_drop;
  logic              unused_full;

  lane_t             sel_reg;
  lane_t             sel_next;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] out_next;
  logic              valid_out_reg;
  logic              valid_out_next;
  logic [1:0]        overflow_reg;

  assign lane_din[0] = in0;
  assign lane_din[1] = in1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (valid_in[gi]),
        .pop   (lane_pop[gi]),
        .din   (lane_din[gi]),
        .dout  (lane_dout[gi]),
        .empty (lane_empty[gi]),
        .full  (lane_full[gi]),
        .drop  (lane_drop[gi])
      );
    end
  endgenerate

  // Full is only informational here; overflow is driven from the FIFO's own drop pulse.
  assign unused_full = ^lane_full;

  always_ff @(posedge clk) begin
    if (reset) sel_reg <= LANE0;
    else       sel_reg <= sel_next;
  end

  always_comb begin
    sel_next = sel_reg;
    if (!lane_empty[sel_reg]) sel_next = (sel_reg == LANE0) ? LANE1 : LANE0;
  end

  always_comb begin
    lane_pop       = '0;
    out_next       = '0;
    valid_out_next = 1'b0;
    if (!lane_empty[sel_reg]) begin
      lane_pop[sel_reg] = 1'b1;
      out_next          = lane_dout[sel_reg];
      valid_out_next    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg       <= '0;
      valid_out_reg <= 1'b0;
      overflow_reg  <= 2'b00;
    end else begin
      out_reg       <= out_next;
      valid_out_reg <= valid_out_next;
      overflow_reg  <= overflow_reg | lane_drop;
    end
  end

  assign out        = out_reg;
  assign valid_out  = valid_out_reg;
  assign overflow   = overflow_reg;
  assign fifo_empty = lane_empty;

endmodule

// File: tb/tb_mux21_lane_merge.sv
// Directed bench for mux21_lane_merge: alternation order, stalls, overflow,
// full-with-pop acceptance, mid-stream reset and pointer wrap.
module tb_mux21_lane_merge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [1:0] valid_in;
  logic [7:0] out;
  logic       valid_out;
  logic [1:0] overflow;
  logic [1:0] fifo_empty;

  int total = 0;
  int bad   = 0;

  mux21_lane_merge dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in1        (in1),
    .valid_in   (valid_in),
    .out        (out),
    .valid_out  (valid_out),
    .overflow   (overflow),
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    valid_in = v;
    in0      = d0;
    in1      = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d);
    $display("%s: valid_out=%0d out=%02h overflow=%b fifo_empty=%b",
             tag, valid_out, out, overflow, fifo_empty);
    chk({tag, " valid"}, valid_out, v);
    chk({tag, " out"}, out, d);
  endtask

  initial begin
    logic [7:0] exp3 [19];
    exp3 = '{8'h00, 8'h80, 8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84,
             8'h05, 8'h85, 8'h06, 8'h86, 8'h07, 8'h88, 8'h09, 8'h8A, 8'h0B};

    reset = 1'b1;
    cyc(2'b00, 8'h00, 8'h00);
    cyc(2'b00, 8'h00, 8'h00);
    reset = 1'b0;
    expect_out("reset", 1'b0, 8'h00);
    chk("reset overflow", overflow, 2'b00);
    chk("reset empty", fifo_empty, 2'b11);

    // 1: paired pushes come out in stripe order
    cyc(2'b11, 8'hA1, 8'hB1);
    expect_out("t1 e1", 1'b0, 8'h00);
    cyc(2'b11, 8'hA2, 8'hB2);
    expect_out("t1 e2", 1'b1, 8'hA1);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t1 e3", 1'b1, 8'hB1);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t1 e4", 1'b1, 8'hA2);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t1 e5", 1'b1, 8'hB2);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t1 e6", 1'b0, 8'h00);
    chk("t1 empty", fifo_empty, 2'b11);

    // 2: lane 1 alone never advances the merger
    cyc(2'b10, 8'h00, 8'h55);
    cyc(2'b10, 8'h00, 8'h55);
    cyc(2'b10, 8'h00, 8'h55);
    expect_out("t2 lane1 only", 1'b0, 8'h00);
    chk("t2 empty", fifo_empty, 2'b01);
    cyc(2'b01, 8'h11, 8'h00);
    expect_out("t2 push0", 1'b0, 8'h00);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t2 o1", 1'b1, 8'h11);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t2 o2", 1'b1, 8'h55);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t2 stall", 1'b0, 8'h00);
    cyc(2'b01, 8'h12, 8'h00);
    expect_out("t2 stall2", 1'b0, 8'h00);
    cyc(2'b01, 8'h13, 8'h00);
    expect_out("t2 o3", 1'b1, 8'h12);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t2 o4", 1'b1, 8'h55);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t2 o5", 1'b1, 8'h13);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t2 o6", 1'b1, 8'h55);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t2 end", 1'b0, 8'h00);
    chk("t2 empty end", fifo_empty, 2'b11);

    // 3: sustained dual-lane input overflows lane 1 first
    reset = 1'b1;
    cyc(2'b00, 8'h00, 8'h00);
    reset = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      cyc((k < 12) ? 2'b11 : 2'b00, 8'(k), 8'(8'h80 + k));
      if (k == 0)       expect_out("t3 k0", 1'b0, 8'h00);
      else if (k <= 19) expect_out($sformatf("t3 k%0d", k), 1'b1, exp3[k-1]);
      else              expect_out("t3 end", 1'b0, 8'h00);
      if (k == 6) chk("t3 ovf k6", overflow, 2'b00);
      if (k == 7) chk("t3 ovf k7", overflow, 2'b10);
      if (k == 8) chk("t3 ovf k8", overflow, 2'b11);
    end
    chk("t3 empty", fifo_empty, 2'b11);

    // 4: full lane 0 accepts a push in the cycle it pops
    reset = 1'b1;
    cyc(2'b00, 8'h00, 8'h00);
    reset = 1'b0;
    cyc(2'b01, 8'hC0, 8'h00);
    expect_out("t4 e1", 1'b0, 8'h00);
    cyc(2'b01, 8'hC1, 8'h00);
    expect_out("t4 e2", 1'b1, 8'hC0);
    cyc(2'b01, 8'hC2, 8'h00);
    cyc(2'b01, 8'hC3, 8'h00);
    cyc(2'b01, 8'hC4, 8'h00);
    expect_out("t4 filled", 1'b0, 8'h00);
    chk("t4 ovf filled", overflow, 2'b00);
    cyc(2'b10, 8'h00, 8'hD0);
    expect_out("t4 e6", 1'b0, 8'h00);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t4 e7", 1'b1, 8'hD0);
    cyc(2'b01, 8'hC5, 8'h00);
    expect_out("t4 e8", 1'b1, 8'hC1);
    chk("t4 ovf push+pop", overflow, 2'b00);
    cyc(2'b01, 8'hC6, 8'h00);
    expect_out("t4 e9", 1'b0, 8'h00);
    chk("t4 ovf still full", overflow, 2'b01);
    cyc(2'b10, 8'h00, 8'hF0);
    expect_out("t4 e10", 1'b0, 8'h00);
    cyc(2'b10, 8'h00, 8'hF1);
    expect_out("t4 e11", 1'b1, 8'hF0);
    cyc(2'b10, 8'h00, 8'hF2);
    expect_out("t4 e12", 1'b1, 8'hC2);
    cyc(2'b10, 8'h00, 8'hF3);
    expect_out("t4 e13", 1'b1, 8'hF1);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t4 e14", 1'b1, 8'hC3);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t4 e15", 1'b1, 8'hF2);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t4 e16", 1'b1, 8'hC4);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t4 e17", 1'b1, 8'hF3);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t4 e18", 1'b1, 8'hC5);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t4 e19", 1'b0, 8'h00);
    chk("t4 empty", fifo_empty, 2'b11);

    // 5: mid-stream reset with 3 bytes buffered and lane 1 selected
    cyc(2'b11, 8'hA0, 8'hB0);
    expect_out("t5 e1", 1'b0, 8'h00);
    cyc(2'b01, 8'h31, 8'h00);
    expect_out("t5 e2", 1'b1, 8'hB0);
    cyc(2'b11, 8'h33, 8'h32);
    expect_out("t5 e3", 1'b1, 8'hA0);
    chk("t5 ovf before reset", overflow, 2'b01);
    chk("t5 empty before reset", fifo_empty, 2'b00);
    reset = 1'b1;
    cyc(2'b00, 8'h00, 8'h00);
    reset = 1'b0;
    expect_out("t5 reset", 1'b0, 8'h00);
    chk("t5 reset empty", fifo_empty, 2'b11);
    chk("t5 reset ovf", overflow, 2'b00);
    cyc(2'b10, 8'h00, 8'h77);
    expect_out("t5 push1", 1'b0, 8'h00);
    cyc(2'b01, 8'h66, 8'h00);
    expect_out("t5 push0", 1'b0, 8'h00);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t5 o1", 1'b1, 8'h66);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t5 o2", 1'b1, 8'h77);
    cyc(2'b00, 8'h00, 8'h00);
    expect_out("t5 end", 1'b0, 8'h00);
    chk("t5 empty end", fifo_empty, 2'b11);

    // 6: ten bytes per lane, pointers wrap past DEPTH
    for (int m = 0; m <= 21; m++) begin
      cyc((m < 20) ? ((m % 2 == 0) ? 2'b01 : 2'b10) : 2'b00,
          8'(8'h40 + m / 2), 8'(8'h50 + m / 2));
      if (m == 0 || m == 21)
        expect_out($sformatf("t6 m%0d", m), 1'b0, 8'h00);
      else if (m % 2 == 1)
        expect_out($sformatf("t6 m%0d", m), 1'b1, 8'(8'h40 + (m - 1) / 2));
      else
        expect_out($sformatf("t6 m%0d", m), 1'b1, 8'(8'h50 + (m - 2) / 2));
    end
    chk("t6 empty", fifo_empty, 2'b11);
    chk("t6 ovf", overflow, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
